parallel_scrambler: RTL and testbench
=====================================

// Module: parallel_scrambler
// PURPOSE
// - Parallel successor to the 1-bit serial scrambler for G(x) = x^58 + x^39 + 1 (64b/66b-style self-synchronous).
// - Processes DATA_W bits per beat; runtime scramble/descramble mode; valid/ready streaming with one registered output stage.
// - Sits between the lane framer and the SERDES gearbox, TX or RX side.
// - DATA_W=1 must be bit-exact with the serial scrambler.
// PARAMETERS
// - DATA_W      64        bits per beat, 1..128; bit 0 is the first serial bit in time
// - RESET_SEED  58'h0     LFSR state after reset or clear
// PORTS
// - CLK        in   1       single clock, rising edge
// - reset_n    in   1       asynchronous, active-low reset
// - clear      in   1       sync: reload RESET_SEED, flush output stage
// - mode       in   1       0 = scramble, 1 = descramble; sampled on accepted beat
// - in_data    in   DATA_W  input beat
// - in_valid   in   1       input beat valid
// - in_ready   out  1       block can accept a beat
// - out_data   out  DATA_W  processed beat
// - out_valid  out  1       out_data valid
// - out_ready  in   1       downstream accepts the beat
// - state      out  58      current LFSR state (debug)
// BEHAVIOUR
// - Reset (reset_n=0, async): s=RESET_SEED, out_valid=0, out_data=0.
//   - in_ready=0 while reset_n=0, 1 from the first edge after release.
// - Per bit i (0..DATA_W-1) of an accepted beat, in serial order:
//   - o[i] = d[i] ^ s[57] ^ s[38]
//   - s = {s[56:0], fb}, where fb = o[i] when scrambling, fb = d[i] when descrambling.
// - Per-beat update is the closed form of DATA_W serial steps (unrolled combinational), not a multi-cycle loop.
// - Accept: in_valid & in_ready.
//   - in_ready = !out_valid | out_ready.
//   - Latency 1 cycle: out_data/out_valid register on the accept edge.
// - s advances only on accept; stalls hold s and out_data stable.
//   - out_data must not change while out_valid & !out_ready.
// - Simultaneous accept and output drain in one cycle: new beat replaces old; full throughput.
// - clear=1 has priority over accept:
//   - s=RESET_SEED, out_valid=0; any in-flight beat is dropped.
//   - in_ready=0 that cycle.
// - mode change mid-stream applies from the next accepted beat; s is not reset.
// - reset_n asserted mid-stream: immediate return to reset values; the pending beat is lost.
// CONFIGURATION
// - Macro SCRAMBLER_BYPASS_EN.
// - Defined: adds input port bypass (1b), sampled per accepted beat.
//   - bypass=1: out_data = in_data, s unchanged; handshake and latency identical.
// - Undefined: no bypass port; all accepted beats are processed.
// STRUCTURE
// - Package scrambler_pkg:
//   - LFSR_LEN=58, TAP_A=57, TAP_B=38
//   - typedef logic [57:0] lfsr_state_t
//   - enum scr_mode_e {SCR_SCRAMBLE, SCR_DESCRAMBLE}
// - Sub-module scrambler_lane_step: combinational DATA_W-step map (in_data, s, mode) -> (out_data, s_next).
// - Top holds the state register, output register and handshake.
// TESTING
// - Scramble, DATA_W=64, seed 0, in_data=64'hFFFF_FFFF_FFFF_FFFF -> out_data=64'hFC00_007F_FFFF_FFFF one cycle later.
// - Round trip: TX scramble -> RX descramble, both seed 0, 10k random beats -> RX out == TX in.
//   - RX starting at random seed: output correct from beat 1 onward (self-sync within 58 bits).
// - DATA_W=1 vs serial reference model, random in/enable stream -> bit-exact output every accepted cycle.
// - Backpressure: out_ready toggled randomly -> no beat lost or duplicated; out_data stable while stalled; state advances only on accept.
// - clear and in_valid asserted in the same cycle -> in_ready=0, out_valid=0 next cycle, state==RESET_SEED.
// - reset_n pulsed low mid-burst -> out_valid drops asynchronously; first post-reset beat matches the seed-0 vector above.

Source files
------------

// File: rtl/scrambler_pkg.sv
// rtl/scrambler_pkg.sv - shared LFSR constants and types for the x^58 + x^39 + 1 scrambler
package scrambler_pkg;

   localparam int LFSR_LEN = 58;
   localparam int TAP_A    = 57;
   localparam int TAP_B    = 38;

   typedef logic [LFSR_LEN-1:0] lfsr_state_t;

   typedef enum logic {
      SCR_SCRAMBLE   = 1'b0,
      SCR_DESCRAMBLE = 1'b1
   } scr_mode_e;

endpackage

// File: rtl/scrambler_lane_step.sv
// rtl/scrambler_lane_step.sv - combinational DATA_W-step map of the self-synchronous scrambler
module scrambler_lane_step
   import scrambler_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0]   in_data,
   input  logic [LFSR_LEN-1:0] state,
   input  scr_mode_e           mode,
   output logic [DATA_W-1:0]   out_data,
   output logic [LFSR_LEN-1:0] state_next
);

   lfsr_state_t s;
   logic        o;

   // Bit 0 is first in time, so the unrolled chain walks upward through the beat.
   always_comb begin
      s        = state;
      o        = 1'b0;
      out_data = '0;
      for (int i = 0; i < DATA_W; i++) begin
         o           = in_data[i] ^ s[TAP_A] ^ s[TAP_B];
         out_data[i] = o;
         s           = {s[LFSR_LEN-2:0], (mode == SCR_DESCRAMBLE) ? in_data[i] : o};
      end
      state_next = s;
   end

endmodule

// File: rtl/parallel_scrambler.sv
// rtl/parallel_scrambler.sv - parallel x^58+x^39+1 scrambler/descrambler, one output register; SCRAMBLER_BYPASS_EN adds bypass
module parallel_scrambler
   import scrambler_pkg::*;
#(
   parameter int          DATA_W     = 64,
   parameter lfsr_state_t RESET_SEED = '0
) (
   input  logic                CLK,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                mode,
`ifdef SCRAMBLER_BYPASS_EN
   input  logic                bypass,
`endif
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LFSR_LEN-1:0] state
);

   lfsr_state_t       lfsr_q;
   lfsr_state_t       lfsr_step;
   lfsr_state_t       lfsr_d;
   logic [DATA_W-1:0] data_step;
   logic [DATA_W-1:0] data_d;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              ready_en_q;
   logic              accept;
   scr_mode_e         mode_e;

   assign mode_e = scr_mode_e'(mode);

   scrambler_lane_step #(
      .DATA_W     (DATA_W)
   ) u_step (
      .in_data    (in_data),
      .state      (lfsr_q),
      .mode       (mode_e),
      .out_data   (data_step),
      .state_next (lfsr_step)
   );

   always_comb begin
      data_d = data_step;
      lfsr_d = lfsr_step;
`ifdef SCRAMBLER_BYPASS_EN
      if (bypass) begin
         data_d = in_data;
         lfsr_d = lfsr_q;
      end
`endif
   end

   // ready_en_q keeps in_ready low until the first edge after reset release.
   assign in_ready = ready_en_q & ~clear & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q      <= RESET_SEED;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         ready_en_q  <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         if (clear) begin
            lfsr_q      <= RESET_SEED;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
         end else if (accept) begin
            lfsr_q      <= lfsr_d;
            out_data_q  <= data_d;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign state     = lfsr_q;

endmodule

// File: tb/tb_parallel_scrambler.sv
// tb/tb_parallel_scrambler.sv - self-checking bench for parallel_scrambler (64-bit, chained RX, 1-bit)
module tb_parallel_scrambler;

   localparam logic [57:0] RX_SEED = 58'h2B5_1C3D_9E0F_4A67;
   localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] ONES_SC = 64'hFC00_007F_FFFF_FFFF;

   logic        CLK = 1'b0;
   logic        reset_n;
   logic        clear, mode, in_valid, in_ready, out_valid, tb_out_ready, dut_out_ready, chain;
   logic [63:0] in_data, out_data;
   logic [57:0] state;

   logic        rx_clear, rx_in_valid, rx_in_ready, rx_out_valid, rx_out_ready;
   logic [63:0] rx_out_data;
   logic [57:0] rx_state;

   logic        s1_clear, s1_mode, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
   logic [0:0]  s1_in_data, s1_out_data;
   logic [57:0] s1_state;

   always #5 CLK = ~CLK;

   assign dut_out_ready = chain ? rx_in_ready : tb_out_ready;
   assign rx_in_valid   = chain & out_valid;

   parallel_scrambler #(.DATA_W(64)) u_dut (
      .CLK(CLK), .reset_n(reset_n), .clear(clear), .mode(mode),
`ifdef SCRAMBLER_BYPASS_EN
      .bypass(1'b0),
`endif
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(dut_out_ready), .state(state)
   );

   parallel_scrambler #(.DATA_W(64), .RESET_SEED(RX_SEED)) u_rx (
      .CLK(CLK), .reset_n(reset_n), .clear(rx_clear), .mode(1'b1),
`ifdef SCRAMBLER_BYPASS_EN
      .bypass(1'b0),
`endif
      .in_data(out_data), .in_valid(rx_in_valid), .in_ready(rx_in_ready),
      .out_data(rx_out_data), .out_valid(rx_out_valid), .out_ready(rx_out_ready), .state(rx_state)
   );

   parallel_scrambler #(.DATA_W(1)) u_s1 (
      .CLK(CLK), .reset_n(reset_n), .clear(s1_clear), .mode(s1_mode),
`ifdef SCRAMBLER_BYPASS_EN
      .bypass(1'b0),
`endif
      .in_data(s1_in_data), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
      .out_data(s1_out_data), .out_valid(s1_out_valid), .out_ready(s1_out_ready), .state(s1_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference: delay line of feedback bits; output taps the bits sent 58 and 39 steps ago.
   bit ring [0:1][0:63];
   int ptr  [0:1];

   task automatic model_seed(input int id, input logic [57:0] seed);
      ptr[id] = 64;
      for (int j = 0; j < 58; j++) ring[id][(ptr[id] - 1 - j) % 64] = seed[j];
   endtask

   task automatic model_beat(input int id, input logic m, input logic [63:0] d, input int n,
                             output logic [63:0] o);
      bit b;
      o = '0;
      for (int i = 0; i < n; i++) begin
         b    = d[i] ^ ring[id][(ptr[id] - 58) % 64] ^ ring[id][(ptr[id] - 39) % 64];
         o[i] = b;
         ring[id][ptr[id] % 64] = m ? d[i] : b;
         ptr[id]++;
      end
   endtask

   function automatic logic [57:0] model_state(input int id);
      logic [57:0] s;
      for (int j = 0; j < 58; j++) s[j] = ring[id][(ptr[id] - 1 - j) % 64];
      return s;
   endfunction

   logic [63:0] exp_q [$];

   // One cycle on the 64-bit DUT, entered and left at a falling edge with inputs already set.
   task automatic tick_main();
      logic        exp_ready, stall;
      logic [63:0] o, held;
      #1;
      exp_ready = !clear && (exp_q.size() == 0 || dut_out_ready);
      check1("in_ready", in_ready, exp_ready);
      stall = exp_q.size() != 0 && !dut_out_ready && !clear;
      held  = out_data;
      if (exp_q.size() != 0 && dut_out_ready) check64("out_data", out_data, exp_q.pop_front());
      if (in_valid && exp_ready) begin
         model_beat(0, mode, in_data, 64, o);
         exp_q.push_back(o);
      end
      @(posedge CLK);
      if (clear) begin
         exp_q.delete();
         model_seed(0, '0);
      end
      @(negedge CLK);
      check1("out_valid", out_valid, exp_q.size() != 0);
      check64("state", 64'(state), 64'(model_state(0)));
      if (stall) check64("stall_hold", out_data, held);
   endtask

   typedef struct {
      logic        m;
      logic [63:0] d;
      logic [63:0] o;
      logic [57:0] s;
   } vec_t;

   vec_t tbl [6];

   initial begin
      logic [63:0] e, o;
      logic        s1_pend, s1_exp;
      int          sent, recv;
      logic [63:0] tx_q [$];

      tbl[0] = '{1'b0, ONES,  ONES_SC,                58'h3FF_FFFF_FE00_003F};
      tbl[1] = '{1'b0, 64'h0, 64'h0,                  58'h0};
      tbl[2] = '{1'b0, 64'h1, 64'h0400_0080_0000_0001, 58'h100_0020};
      tbl[3] = '{1'b1, ONES,  ONES_SC,                58'h3FF_FFFF_FFFF_FFFF};
      tbl[4] = '{1'b1, 64'h1, 64'h0400_0080_0000_0001, 58'h0};
      tbl[5] = '{1'b1, 64'h0, 64'h0,                  58'h0};

      reset_n = 1'b0; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
      tb_out_ready = 1'b1; chain = 1'b0; rx_clear = 1'b0; rx_out_ready = 1'b1;
      s1_clear = 1'b0; s1_mode = 1'b0; s1_in_valid = 1'b0; s1_in_data = '0; s1_out_ready = 1'b1;
      model_seed(0, '0);
      model_seed(1, '0);

      @(negedge CLK); @(negedge CLK);
      check1("rst_out_valid", out_valid, 1'b0);
      check64("rst_out_data", out_data, 64'h0);
      check64("rst_state", 64'(state), 64'h0);
      check1("rst_in_ready", in_ready, 1'b0);
      check64("rst_rx_state", 64'(rx_state), 64'(RX_SEED));
      reset_n = 1'b1;
      #1 check1("in_ready_before_edge", in_ready, 1'b0);
      @(posedge CLK); @(negedge CLK);
      check1("in_ready_after_edge", in_ready, 1'b1);

      // Table vectors, each from a freshly cleared seed.
      for (int k = 0; k < 6; k++) begin
         clear = 1'b1; in_valid = 1'b0;
         tick_main();
         clear = 1'b0; mode = tbl[k].m; in_data = tbl[k].d; in_valid = 1'b1;
         tick_main();
         in_valid = 1'b0;
         check64($sformatf("tbl%0d_data", k), out_data, tbl[k].o);
         check64($sformatf("tbl%0d_state", k), 64'(state), 64'(tbl[k].s));
         tick_main();
      end

      // Random traffic with backpressure, mode changes and occasional clears.
      for (int c = 0; c < 3000; c++) begin
         in_valid     = ($urandom % 4) != 0;
         in_data      = {$urandom, $urandom};
         if (($urandom % 16) == 0) mode = ~mode;
         tb_out_ready = ($urandom % 3) != 0;
         clear        = ($urandom % 97) == 0;
         tick_main();
      end
      clear = 1'b0;

      // Clear while a stalled beat is held and a new beat is offered.
      in_valid = 1'b1; in_data = {$urandom, $urandom}; tb_out_ready = 1'b0;
      tick_main();
      check1("pre_clear_valid", out_valid, 1'b1);
      clear = 1'b1;
      tick_main();
      clear = 1'b0; in_valid = 1'b0;
      check1("clear_out_valid", out_valid, 1'b0);
      check64("clear_state", 64'(state), 64'h0);
      tb_out_ready = 1'b1;

      // Asynchronous reset in the middle of a burst.
      mode = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_data = {$urandom, $urandom};
         tick_main();
      end
      tb_out_ready = 1'b0;
      tick_main();
      #2 reset_n = 1'b0;
      #1;
      check1("async_out_valid", out_valid, 1'b0);
      check64("async_out_data", out_data, 64'h0);
      check64("async_state", 64'(state), 64'h0);
      check1("async_in_ready", in_ready, 1'b0);
      in_valid = 1'b0; tb_out_ready = 1'b1;
      @(negedge CLK);
      reset_n = 1'b1;
      exp_q.delete();
      model_seed(0, '0);
      @(posedge CLK); @(negedge CLK);
      in_valid = 1'b1; in_data = ONES; mode = 1'b0;
      tick_main();
      in_valid = 1'b0;
      check64("post_reset_vector", out_data, ONES_SC);
      tick_main();

      // TX scramble into RX descramble starting from a different seed.
      clear = 1'b1; rx_clear = 1'b1;
      @(posedge CLK); @(negedge CLK);
      clear = 1'b0; rx_clear = 1'b0; chain = 1'b1; mode = 1'b0;
      sent = 0; recv = 0;
      for (int c = 0; c < 40000 && recv < 10000; c++) begin
         in_valid     = (sent < 10000) && (($urandom % 4) != 0);
         in_data      = {$urandom, $urandom};
         rx_out_ready = ($urandom % 4) != 0;
         #1;
         if (rx_out_valid && rx_out_ready) begin
            if (tx_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL roundtrip_extra: got beat %h with nothing sent", rx_out_data);
            end else begin
               e = tx_q.pop_front();
               if (recv >= 1) check64("roundtrip", rx_out_data, e);
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            tx_q.push_back(in_data);
            sent++;
         end
         @(posedge CLK); @(negedge CLK);
      end
      check64("roundtrip_count", 64'(recv), 64'd10000);
      chain = 1'b0; in_valid = 1'b0;

      // DATA_W=1 against the serial reference, scramble then descramble without reseeding.
      model_seed(1, '0);
      for (int c = 0; c < 2000; c++) begin
         s1_in_valid = $urandom % 2;
         s1_in_data  = 1'($urandom % 2);
         s1_mode     = c >= 1000;
         #1;
         s1_pend = s1_in_valid;
         s1_exp  = 1'b0;
         if (s1_in_valid) begin
            check1("s1_in_ready", s1_in_ready, 1'b1);
            model_beat(1, s1_mode, {63'b0, s1_in_data}, 1, o);
            s1_exp = o[0];
         end
         @(posedge CLK); @(negedge CLK);
         check1("s1_out_valid", s1_out_valid, s1_pend);
         if (s1_pend) check1("s1_out_data", s1_out_data[0], s1_exp);
         check64("s1_state", 64'(s1_state), 64'(model_state(1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
